// File: rtl/ofdm_rx_pkg.sv
// Shared types and constants for the OFDM receive packet sequencer.
package ofdm_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIG_RST,
    ST_SIG_DEC,
    ST_SIG_CHECK,
    ST_DATA_RST,
    ST_DATA_DEC
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_RATE    = 3'd1;
  localparam logic [2:0] ERR_PARITY  = 3'd2;
  localparam logic [2:0] ERR_TAIL    = 3'd3;
  localparam logic [2:0] ERR_LENGTH  = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_ABORT   = 3'd6;

  localparam logic [7:0]  SIG_RATE_CODE      = 8'h0B;
  localparam logic [31:0] SIG_NUM_BITS       = 32'd24;
  localparam logic [31:0] DATA_OVERHEAD_BITS = 32'd22;

  // DATA field bit budget: 8 bits per PSDU byte plus SERVICE/tail overhead.
  function automatic logic [31:0] data_num_bits(input logic [11:0] len);
    return {17'd0, len, 3'd0} + DATA_OVERHEAD_BITS;
  endfunction

endpackage

// File: rtl/ofdm_signal_parser.sv
// Combinational decode and validation of the 24-bit SIGNAL field.
module ofdm_signal_parser
  import ofdm_rx_pkg::*;
#(
  parameter int unsigned MAX_LEN = 4095
) (
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  output logic        ok,
  output logic [2:0]  err_code,
  output logic [3:0]  rate,
  output logic [11:0] len
);

  logic [23:0] word;

  assign word = {b2, b1, b0};

  // Checks are ordered so the highest-priority failure is the one reported.
  always_comb begin
    rate     = word[3:0];
    len      = word[16:5];
    err_code = ERR_NONE;
    if (!word[3])
      err_code = ERR_RATE;
    else if (^word[17:0])
      err_code = ERR_PARITY;
    else if (word[4] || (word[23:18] != '0))
      err_code = ERR_TAIL;
    else if ((len == '0) || ({20'd0, len} > 32'(MAX_LEN)))
      err_code = ERR_LENGTH;
    ok = (err_code == ERR_NONE);
  end

endmodule

// File: rtl/ofdm_rx_sequencer.sv
// Packet-level controller: runs the decoder over SIGNAL, validates it, then
// reconfigures the decoder for DATA and forwards PSDU bytes.
module ofdm_rx_sequencer
  import ofdm_rx_pkg::*;
#(
  parameter int unsigned MAX_LEN = 4095,
  parameter logic [15:0] TIMEOUT = 16'd40000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        sample_gate,
  output logic        dec_reset,
  output logic [7:0]  dec_rate,
  output logic        dec_do_descramble,
  output logic [31:0] dec_num_bits,
  input  logic [7:0]  dec_byte,
  input  logic        dec_byte_strobe,
  output logic        sig_valid,
  output logic [3:0]  sig_rate,
  output logic [11:0] sig_len,
  output logic        sig_error,
  output logic [2:0]  err_code,
  output logic [7:0]  byte_out,
  output logic        byte_out_strobe,
  output logic        pkt_done,
  output logic        busy
);

  state_t      state, state_next;
  logic [7:0]  b0, b1, b2;
  logic [1:0]  sig_cnt;
  logic [11:0] data_cnt;
  logic        svc_dropped;
  logic [15:0] wd;

  logic        p_ok;
  logic [2:0]  p_err;
  logic [3:0]  p_rate;
  logic [11:0] p_len;

  logic        in_dec, wd_expire;
  logic        load_sig, valid_fire, err_fire, fwd_fire, done_fire;
  logic [2:0]  err_val;

  ofdm_signal_parser #(.MAX_LEN(MAX_LEN)) u_parser (
    .b0       (b0),
    .b1       (b1),
    .b2       (b2),
    .ok       (p_ok),
    .err_code (p_err),
    .rate     (p_rate),
    .len      (p_len)
  );

  assign in_dec      = (state == ST_SIG_DEC) || (state == ST_DATA_DEC);
  assign sample_gate = in_dec;
  assign dec_reset   = (state == ST_SIG_RST) || (state == ST_DATA_RST);
  assign busy        = (state != ST_IDLE);
  // Fires on the edge at which the counter would reach TIMEOUT.
  assign wd_expire   = in_dec && !dec_byte_strobe && (wd == TIMEOUT - 16'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_sig   = 1'b0;
    valid_fire = 1'b0;
    err_fire   = 1'b0;
    err_val    = ERR_NONE;
    fwd_fire   = 1'b0;
    done_fire  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_sig   = 1'b1;
          state_next = ST_SIG_RST;
        end
      end
      ST_SIG_RST: state_next = ST_SIG_DEC;
      ST_SIG_DEC: begin
        if (dec_byte_strobe && (sig_cnt == 2'd2)) begin
          state_next = ST_SIG_CHECK;
        end else if (wd_expire) begin
          err_fire   = 1'b1;
          err_val    = ERR_TIMEOUT;
          state_next = ST_IDLE;
        end
      end
      ST_SIG_CHECK: begin
        if (p_ok) begin
          valid_fire = 1'b1;
          state_next = ST_DATA_RST;
        end else begin
          err_fire   = 1'b1;
          err_val    = p_err;
          state_next = ST_IDLE;
        end
      end
      ST_DATA_RST: state_next = ST_DATA_DEC;
      ST_DATA_DEC: begin
        if (dec_byte_strobe) begin
          if (svc_dropped) begin
            fwd_fire = 1'b1;
            if (data_cnt + 12'd1 == sig_len) begin
              done_fire  = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end else if (wd_expire) begin
          err_fire   = 1'b1;
          err_val    = ERR_TIMEOUT;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Abort overrides every other outcome, including a coincident final byte.
    if ((state != ST_IDLE) && abort) begin
      state_next = ST_IDLE;
      valid_fire = 1'b0;
      fwd_fire   = 1'b0;
      done_fire  = 1'b0;
      err_fire   = 1'b1;
      err_val    = ERR_ABORT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_rate          <= SIG_RATE_CODE;
      dec_do_descramble <= 1'b0;
      dec_num_bits      <= '0;
      sig_valid         <= 1'b0;
      sig_rate          <= '0;
      sig_len           <= '0;
      sig_error         <= 1'b0;
      err_code          <= '0;
      byte_out          <= '0;
      byte_out_strobe   <= 1'b0;
      pkt_done          <= 1'b0;
      b0                <= '0;
      b1                <= '0;
      b2                <= '0;
      sig_cnt           <= '0;
      data_cnt          <= '0;
      svc_dropped       <= 1'b0;
      wd                <= '0;
    end else begin
      sig_valid       <= valid_fire;
      sig_error       <= err_fire;
      byte_out_strobe <= fwd_fire;
      pkt_done        <= done_fire;
      if (err_fire) err_code <= err_val;
      if (fwd_fire) byte_out <= dec_byte;

      if (load_sig) begin
        sig_rate          <= '0;
        sig_len           <= '0;
        dec_rate          <= SIG_RATE_CODE;
        dec_do_descramble <= 1'b0;
        dec_num_bits      <= SIG_NUM_BITS;
        sig_cnt           <= '0;
      end

      if ((state == ST_SIG_DEC) && dec_byte_strobe) begin
        case (sig_cnt)
          2'd0:    b0 <= dec_byte;
          2'd1:    b1 <= dec_byte;
          default: b2 <= dec_byte;
        endcase
        sig_cnt <= sig_cnt + 2'd1;
      end

      if (valid_fire) begin
        sig_rate          <= p_rate;
        sig_len           <= p_len;
        dec_rate          <= {4'b0, p_rate};
        dec_do_descramble <= 1'b1;
        dec_num_bits      <= data_num_bits(p_len);
        data_cnt          <= '0;
        svc_dropped       <= 1'b0;
      end

      if ((state == ST_DATA_DEC) && dec_byte_strobe) svc_dropped <= 1'b1;
      if (fwd_fire) data_cnt <= data_cnt + 12'd1;

      if (dec_reset || dec_byte_strobe) wd <= '0;
      else if (in_dec)                  wd <= wd + 16'd1;
    end
  end

endmodule

// File: tb/tb_ofdm_rx_sequencer.sv
// Scoreboard bench for ofdm_rx_sequencer: directed SIGNAL/DATA vectors with
// hand-computed expectations, checked by an independent output monitor.
module tb_ofdm_rx_sequencer;

  localparam logic [15:0] TB_TIMEOUT = 16'd1000;

  localparam logic [3:0] K_NONE = 4'd0, K_VALID = 4'd1, K_ERROR = 4'd2,
                         K_DECRST = 4'd3, K_BYTE = 4'd4;

  localparam logic [74:0] RST_VEC = {2'b00, 8'h0B, 1'b0, 32'd0, 1'b0, 4'd0,
                                     12'd0, 1'b0, 3'd0, 8'd0, 3'b000};

  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] a;
    logic [31:0] b;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sample_gate, dec_reset, dec_do_descramble;
  logic [7:0]  dec_rate;
  logic [31:0] dec_num_bits;
  logic [7:0]  dec_byte = '0;
  logic        dec_byte_strobe = 1'b0;
  logic        sig_valid, sig_error, byte_out_strobe, pkt_done, busy;
  logic [3:0]  sig_rate;
  logic [11:0] sig_len;
  logic [2:0]  err_code;
  logic [7:0]  byte_out;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  ofdm_rx_sequencer #(.MAX_LEN(4095), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .sample_gate       (sample_gate),
    .dec_reset         (dec_reset),
    .dec_rate          (dec_rate),
    .dec_do_descramble (dec_do_descramble),
    .dec_num_bits      (dec_num_bits),
    .dec_byte          (dec_byte),
    .dec_byte_strobe   (dec_byte_strobe),
    .sig_valid         (sig_valid),
    .sig_rate          (sig_rate),
    .sig_len           (sig_len),
    .sig_error         (sig_error),
    .err_code          (err_code),
    .byte_out          (byte_out),
    .byte_out_strobe   (byte_out_strobe),
    .pkt_done          (pkt_done),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [3:0] kind, input logic [15:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    sb.push_back(e);
  endfunction

  function automatic logic [74:0] out_vec();
    return {sample_gate, dec_reset, dec_rate, dec_do_descramble, dec_num_bits,
            sig_valid, sig_rate, sig_len, sig_error, err_code, byte_out,
            byte_out_strobe, pkt_done, busy};
  endfunction

  task automatic sb_compare(input string name, input ev_t act);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event %0h, scoreboard empty (t=%0t)", name, act, $time);
    end else begin
      e = sb.pop_front();
      check(name, {44'd0, act}, {44'd0, e});
    end
  endtask

  // Monitor: pops one expectation per observed DUT event, in a fixed order.
  initial begin
    ev_t act;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (sig_valid) begin
          act = '{kind: K_VALID, a: {12'd0, sig_rate}, b: {20'd0, sig_len}};
          sb_compare("sig_valid", act);
        end
        if (sig_error) begin
          act = '{kind: K_ERROR, a: {13'd0, err_code}, b: 32'd0};
          sb_compare("sig_error", act);
        end
        if (dec_reset) begin
          act = '{kind: K_DECRST, a: {7'd0, dec_rate, dec_do_descramble}, b: dec_num_bits};
          sb_compare("dec_cfg", act);
        end
        if (byte_out_strobe || pkt_done) begin
          act = '{kind: (byte_out_strobe ? K_BYTE : K_NONE), a: {8'd0, byte_out}, b: {31'd0, pkt_done}};
          sb_compare("byte_out", act);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_abort);
    dec_byte        = b;
    dec_byte_strobe = 1'b1;
    abort           = with_abort;
    tick();
    dec_byte_strobe = 1'b0;
    abort           = 1'b0;
    tick();
  endtask

  task automatic wait_gate(input string name);
    int n = 0;
    while (!sample_gate && n < 8) begin
      tick();
      n++;
    end
    check(name, {95'd0, sample_gate}, 96'd1);
  endtask

  // Runs a SIGNAL field; ok packets also expect the DATA reconfiguration.
  task automatic run_signal(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic ok, input logic [2:0] code, input logic [3:0] rate,
                            input logic [11:0] len, input logic [31:0] nbits);
    push(K_DECRST, {7'd0, 8'h0B, 1'b0}, 32'd24);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_gate("sig_gate");
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    if (ok) begin
      push(K_VALID, {12'd0, rate}, {20'd0, len});
      push(K_DECRST, {7'd0, 4'd0, rate, 1'b1}, nbits);
    end else begin
      push(K_ERROR, {13'd0, code}, 32'd0);
    end
    send_byte(b2, 1'b0);
  endtask

  // Sends the SERVICE byte plus n_bytes more; bytes 1..len are expected out.
  task automatic run_data(input int unsigned n_bytes, input int unsigned len);
    wait_gate("data_gate");
    for (int unsigned i = 0; i <= n_bytes; i++) begin
      logic [7:0] v;
      v = 8'(i * 3 + 17);
      if (i >= 1 && i <= len) push(K_BYTE, {8'd0, v}, {31'd0, (i == len)});
      send_byte(v, 1'b0);
    end
  endtask

  task automatic error_case(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [2:0] code);
    run_signal(b0, b1, b2, 1'b0, code, 4'd0, 12'd0, 32'd0);
    repeat (3) tick();
    check("err_idle_busy", {95'd0, busy}, 96'd0);
    check("err_no_data_cfg", {64'd0, dec_num_bits}, 96'd24);
  endtask

  initial begin
    int n;
    #23;
    check("reset_state", {21'd0, out_vec()}, {21'd0, RST_VEC});
    reset = 1'b0;
    repeat (2) tick();
    check("idle_busy", {95'd0, busy}, 96'd0);

    // Good packet: 8B 0C 00 -> rate B, len 100, 822 DATA bits.
    run_signal(8'h8B, 8'h0C, 8'h00, 1'b1, 3'd0, 4'hB, 12'd100, 32'd822);
    run_data(102, 100);
    repeat (2) tick();
    check("pkt_busy", {95'd0, busy}, 96'd0);
    check("sig_len_hold", {84'd0, sig_len}, 96'd100);

    // Rejects; 0B 00 00 has odd parity, so parity outranks its zero length.
    error_case(8'h8B, 8'h0C, 8'h02, 3'd2);
    error_case(8'h8B, 8'h0C, 8'h04, 3'd3);
    error_case(8'h83, 8'h0C, 8'h00, 3'd1);
    error_case(8'h0B, 8'h00, 8'h02, 3'd4);
    error_case(8'h0B, 8'h00, 8'h00, 3'd2);

    // Timeout after a single SIGNAL byte.
    push(K_DECRST, {7'd0, 8'h0B, 1'b0}, 32'd24);
    push(K_ERROR, {13'd0, 3'd5}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_gate("to_gate");
    dec_byte        = 8'h8B;
    dec_byte_strobe = 1'b1;
    tick();
    dec_byte_strobe = 1'b0;
    n = 0;
    while (!sig_error && n < int'(TB_TIMEOUT) + 20) begin
      tick();
      n++;
    end
    check("timeout_latency", 96'(n), 96'(TB_TIMEOUT));
    tick();
    check("timeout_busy", {95'd0, busy}, 96'd0);

    // len 1 packet (2B 00 00): abort coincident with the final byte wins.
    run_signal(8'h2B, 8'h00, 8'h00, 1'b1, 3'd0, 4'hB, 12'd1, 32'd30);
    wait_gate("len1_gate");
    send_byte(8'h55, 1'b0);
    push(K_ERROR, {13'd0, 3'd6}, 32'd0);
    send_byte(8'hA5, 1'b1);
    check("abort_final_busy", {95'd0, busy}, 96'd0);

    // Abort with DATA byte 50.
    run_signal(8'h8B, 8'h0C, 8'h00, 1'b1, 3'd0, 4'hB, 12'd100, 32'd822);
    run_data(49, 100);
    push(K_ERROR, {13'd0, 3'd6}, 32'd0);
    dec_byte        = 8'h77;
    dec_byte_strobe = 1'b1;
    abort           = 1'b1;
    tick();
    dec_byte_strobe = 1'b0;
    abort           = 1'b0;
    check("abort_busy_next", {95'd0, busy}, 96'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);

    // Asynchronous reset mid-DATA.
    run_signal(8'h8B, 8'h0C, 8'h00, 1'b1, 3'd0, 4'hB, 12'd100, 32'd822);
    run_data(10, 100);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_data", {21'd0, out_vec()}, {21'd0, RST_VEC});
    tick();
    reset = 1'b0;
    tick();

    // Clean packet after all the errors and the reset.
    run_signal(8'h8B, 8'h0C, 8'h00, 1'b1, 3'd0, 4'hB, 12'd100, 32'd822);
    run_data(101, 100);
    repeat (4) tick();
    check("final_busy", {95'd0, busy}, 96'd0);
    check("scoreboard_drained", 96'(sb.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
